// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ALU control sequencer: states, opcodes,
// funct codes and the select/operation codes driven onto the datapath.
package ctrl_pkg;

    localparam logic [3:0] S_RST      = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_EXEC_LUI = 4'd5;
    localparam logic [3:0] S_WB_R     = 4'd6;
    localparam logic [3:0] S_WB_I     = 4'd7;
    localparam logic [3:0] S_MEM_ADDR = 4'd8;
    localparam logic [3:0] S_MEM_ACC  = 4'd9;
    localparam logic [3:0] S_WB_MEM   = 4'd10;
    localparam logic [3:0] S_EXEC_BR  = 4'd11;
    localparam logic [3:0] S_EXEC_J   = 4'd12;
    localparam logic [3:0] S_EXCECAO  = 4'd13;

    typedef enum logic [3:0] {
        ST_RST      = S_RST,
        ST_FETCH    = S_FETCH,
        ST_DECODE   = S_DECODE,
        ST_EXEC_R   = S_EXEC_R,
        ST_EXEC_I   = S_EXEC_I,
        ST_EXEC_LUI = S_EXEC_LUI,
        ST_WB_R     = S_WB_R,
        ST_WB_I     = S_WB_I,
        ST_MEM_ADDR = S_MEM_ADDR,
        ST_MEM_ACC  = S_MEM_ACC,
        ST_WB_MEM   = S_WB_MEM,
        ST_EXEC_BR  = S_EXEC_BR,
        ST_EXEC_J   = S_EXEC_J,
        ST_EXCECAO  = S_EXCECAO
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [2:0] M1_PC    = 3'b000;
    localparam logic [2:0] M1_EXT26 = 3'b010;
    localparam logic [2:0] M1_ZERO  = 3'b011;
    localparam logic [2:0] M1_A     = 3'b100;
    localparam logic [2:0] M1_MEM   = 3'b101;

    localparam logic [2:0] M2_B        = 3'b000;
    localparam logic [2:0] M2_CONST4   = 3'b001;
    localparam logic [2:0] M2_SEXT     = 3'b010;
    localparam logic [2:0] M2_SEXT_SH2 = 3'b011;
    localparam logic [2:0] M2_IMM_HI   = 3'b100;

    localparam logic [2:0] ULA_ADD = 3'b001;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [2:0] ULA_AND = 3'b011;
    localparam logic [2:0] ULA_OR  = 3'b100;

    localparam logic [1:0] PCS_ULA    = 2'b00;
    localparam logic [1:0] PCS_ULAOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/ula_op_decode.sv
// R-type funct decoder: maps Funct onto an ALU operation code and flags
// any funct the ALU cannot execute.
module ula_op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_ula_op,
    output logic       o_ilegal
);

    always_comb begin
        o_ula_op = ULA_ADD;
        o_ilegal = 1'b0;
        case (i_funct)
            FN_ADD:  o_ula_op = ULA_ADD;
            FN_SUB:  o_ula_op = ULA_SUB;
            FN_AND:  o_ula_op = ULA_AND;
            FN_OR:   o_ula_op = ULA_OR;
            default: o_ilegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_ula_seq.sv
// Multicycle control FSM: sequences ALU operand selects, ALU op and datapath
// write enables through fetch/decode/execute/memory/writeback.
module controle_ula_seq
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemPronta,
    output logic [2:0] MuxULA1,
    output logic [2:0] MuxULA2,
    output logic [2:0] ULAOp,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       ULAOutWrite,
    output logic [1:0] PCSource,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       Excecao,
    output logic [3:0] Estado
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] LP_MAX     = '1;

    state_t           r_estado;
    state_t           w_prox;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_prox;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic [2:0]       w_funct_op;
    logic             w_funct_ilegal;

    ula_op_decode u_ula_op_decode (
        .i_funct  (Funct),
        .o_ula_op (w_funct_op),
        .o_ilegal (w_funct_ilegal)
    );

    // Saturating wait counter; timeout fires on the cycle it would reach the limit.
    assign w_cnt_inc = (r_cnt == LP_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc >= LP_TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= ST_RST;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_prox;
            r_cnt    <= w_cnt_prox;
        end
    end

    assign Estado = r_estado;

    always_comb begin
        w_prox      = r_estado;
        w_cnt_prox  = '0;
        MuxULA1     = M1_PC;
        MuxULA2     = M2_B;
        ULAOp       = ULA_ADD;
        PCSource    = PCS_ULA;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        ULAOutWrite = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        Excecao     = 1'b0;

        case (r_estado)
            ST_RST: w_prox = ST_FETCH;

            ST_FETCH: begin
                MemRead = 1'b1;
                MuxULA1 = M1_PC;
                MuxULA2 = M2_CONST4;
                ULAOp   = ULA_ADD;
                if (MemPronta) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_prox  = ST_DECODE;
                end else if (w_timeout) begin
                    w_prox = ST_EXCECAO;
                end else begin
                    w_cnt_prox = w_cnt_inc;
                end
            end

            ST_DECODE: begin
                MuxULA1     = M1_PC;
                MuxULA2     = M2_SEXT_SH2;
                ULAOutWrite = 1'b1;
                case (Opcode)
                    OP_R:           w_prox = ST_EXEC_R;
                    OP_ADDI:        w_prox = ST_EXEC_I;
                    OP_LUI:         w_prox = ST_EXEC_LUI;
                    OP_LW, OP_SW:   w_prox = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_prox = ST_EXEC_BR;
                    OP_J:           w_prox = ST_EXEC_J;
                    default:        w_prox = ST_EXCECAO;
                endcase
            end

            ST_EXEC_R: begin
                MuxULA1 = M1_A;
                MuxULA2 = M2_B;
                ULAOp   = w_funct_op;
                if (w_funct_ilegal) begin
                    w_prox = ST_EXCECAO;
                end else begin
                    ULAOutWrite = 1'b1;
                    w_prox      = ST_WB_R;
                end
            end

            ST_EXEC_I: begin
                MuxULA1     = M1_A;
                MuxULA2     = M2_SEXT;
                ULAOutWrite = 1'b1;
                w_prox      = ST_WB_I;
            end

            ST_EXEC_LUI: begin
                MuxULA1     = M1_ZERO;
                MuxULA2     = M2_IMM_HI;
                ULAOutWrite = 1'b1;
                w_prox      = ST_WB_I;
            end

            ST_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                w_prox   = ST_FETCH;
            end

            ST_WB_I: begin
                RegWrite = 1'b1;
                w_prox   = ST_FETCH;
            end

            ST_MEM_ADDR: begin
                MuxULA1     = M1_A;
                MuxULA2     = M2_SEXT;
                ULAOutWrite = 1'b1;
                w_prox      = ST_MEM_ACC;
            end

            ST_MEM_ACC: begin
                MemRead  = (Opcode == OP_LW);
                MemWrite = (Opcode == OP_SW);
                if (MemPronta) begin
                    w_prox = (Opcode == OP_LW) ? ST_WB_MEM : ST_FETCH;
                end else if (w_timeout) begin
                    w_prox = ST_EXCECAO;
                end else begin
                    w_cnt_prox = w_cnt_inc;
                end
            end

            ST_WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                w_prox   = ST_FETCH;
            end

            ST_EXEC_BR: begin
                MuxULA1  = M1_A;
                MuxULA2  = M2_B;
                ULAOp    = ULA_SUB;
                PCSource = PCS_ULAOUT;
                PCWrite  = (Opcode == OP_BEQ) ? Zero : ~Zero;
                w_prox   = ST_FETCH;
            end

            ST_EXEC_J: begin
                PCWrite  = 1'b1;
                PCSource = PCS_JUMP;
                w_prox   = ST_FETCH;
            end

            ST_EXCECAO: Excecao = 1'b1;

            default: w_prox = ST_RST;
        endcase

        // A reset cycle must never leak a write enable from whatever state it interrupts.
        if (reset) begin
            MuxULA1     = M1_PC;
            MuxULA2     = M2_B;
            ULAOp       = ULA_ADD;
            PCSource    = PCS_ULA;
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            ULAOutWrite = 1'b0;
            RegDst      = 1'b0;
            MemToReg    = 1'b0;
            Excecao     = 1'b0;
        end
    end

endmodule

// File: tb/tb_controle_ula_seq.sv
// Directed bench for controle_ula_seq: walks each instruction class, the
// memory wait/timeout paths and the exception/reset behaviour.
module tb_controle_ula_seq;

    logic       clock;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemPronta;
    logic [2:0] MuxULA1;
    logic [2:0] MuxULA2;
    logic [2:0] ULAOp;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       ULAOutWrite;
    logic [1:0] PCSource;
    logic       RegDst;
    logic       MemToReg;
    logic       Excecao;
    logic [3:0] Estado;

    int n_checks = 0;
    int n_errors = 0;

    controle_ula_seq #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Zero        (Zero),
        .MemPronta   (MemPronta),
        .MuxULA1     (MuxULA1),
        .MuxULA2     (MuxULA2),
        .ULAOp       (ULAOp),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .ULAOutWrite (ULAOutWrite),
        .PCSource    (PCSource),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .Excecao     (Excecao),
        .Estado      (Estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs may change right after, checks settle before the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset     = 1'b1;
        Opcode    = 6'h00;
        Funct     = 6'h00;
        Zero      = 1'b0;
        MemPronta = 1'b0;

        repeat (3) tick();
        settle();
        chk("rst_estado", Estado, 4'd0);
        chk("rst_excecao", Excecao, 1'b0);
        chk("rst_memread", MemRead, 1'b0);

        reset = 1'b0; MemPronta = 1'b1; Opcode = 6'h00; Funct = 6'h22;
        settle();
        chk("rst_release_estado", Estado, 4'd0);
        tick(); settle();
        chk("fetch_estado", Estado, 4'd1);
        chk("fetch_mux", {MuxULA1, MuxULA2, ULAOp}, {3'b000, 3'b001, 3'b001});
        chk("fetch_en", {IRWrite, PCWrite, MemRead}, 3'b111);
        tick(); settle();
        chk("decode_estado", Estado, 4'd2);
        chk("decode_sel", {MuxULA1, MuxULA2, ULAOutWrite}, {3'b000, 3'b011, 1'b1});
        tick(); settle();
        chk("execr_estado", Estado, 4'd3);
        chk("execr_sel", {MuxULA1, MuxULA2, ULAOp, ULAOutWrite}, {3'b100, 3'b000, 3'b010, 1'b1});
        tick(); settle();
        chk("wbr_estado", Estado, 4'd6);
        chk("wbr_en", {RegWrite, RegDst, MemToReg}, 3'b110);
        tick(); settle();
        chk("wbr_back_fetch", Estado, 4'd1);

        // beq taken
        Opcode = 6'h04; Zero = 1'b1;
        tick(); tick(); settle();
        chk("beq_estado", Estado, 4'd11);
        chk("beq_out", {PCWrite, PCSource, ULAOp, MuxULA1}, {1'b1, 2'b01, 3'b010, 3'b100});
        tick(); settle();
        chk("beq_back_fetch", Estado, 4'd1);

        // bne with Zero high is not taken, with Zero low is taken
        Opcode = 6'h05; Zero = 1'b1;
        tick(); tick(); settle();
        chk("bne_z1_pcwrite", PCWrite, 1'b0);
        Zero = 1'b0; settle();
        chk("bne_z0_pcwrite", PCWrite, 1'b1);
        tick(); settle();

        Opcode = 6'h0F;
        tick(); tick(); settle();
        chk("lui_estado", Estado, 4'd5);
        chk("lui_sel", {MuxULA1, MuxULA2, ULAOutWrite}, {3'b011, 3'b100, 1'b1});
        tick(); settle();
        chk("wbi_en", {Estado, RegWrite, RegDst, MemToReg}, {4'd7, 3'b100});
        tick(); settle();

        Opcode = 6'h08;
        tick(); tick(); settle();
        chk("addi_sel", {Estado, MuxULA1, MuxULA2}, {4'd4, 3'b100, 3'b010});
        tick(); tick(); settle();

        // lw with five cycles of memory wait
        Opcode = 6'h23;
        tick(); tick(); settle();
        chk("lw_memaddr", {Estado, MuxULA1, MuxULA2, ULAOutWrite}, {4'd8, 3'b100, 3'b010, 1'b1});
        MemPronta = 1'b0;
        tick(); settle();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("lw_wait%0d", i), {Estado, MemRead, MemWrite}, {4'd9, 2'b10});
            tick(); settle();
        end
        MemPronta = 1'b1; settle();
        chk("lw_ready", {Estado, MemRead}, {4'd9, 1'b1});
        tick(); settle();
        chk("wbmem_en", {Estado, RegWrite, RegDst, MemToReg}, {4'd10, 3'b101});
        tick(); settle();

        Opcode = 6'h2B;
        tick(); tick(); tick(); settle();
        chk("sw_acc", {Estado, MemRead, MemWrite}, {4'd9, 2'b01});
        tick(); settle();
        chk("sw_back_fetch", Estado, 4'd1);

        Opcode = 6'h02;
        tick(); tick(); settle();
        chk("j_out", {Estado, PCWrite, PCSource}, {4'd12, 1'b1, 2'b10});
        tick(); settle();

        // Reset in the middle of WB_R: no write enable in that cycle
        Opcode = 6'h00; Funct = 6'h25;
        tick(); tick(); settle();
        chk("or_ulaop", ULAOp, 3'b100);
        tick(); settle();
        reset = 1'b1; settle();
        chk("mid_rst_regwrite", RegWrite, 1'b0);
        tick(); settle();
        chk("mid_rst_estado", Estado, 4'd0);

        // Illegal funct
        reset = 1'b0; Funct = 6'h3F;
        tick(); tick(); tick(); settle();
        chk("badfn_ulaoutwrite", {Estado, ULAOutWrite}, {4'd3, 1'b0});
        tick(); settle();
        chk("badfn_excecao", {Estado, Excecao}, {4'd13, 1'b1});

        // Fetch timeout: 15 waiting cycles then EXCECAO
        reset = 1'b1; tick();
        reset = 1'b0; MemPronta = 1'b0; Opcode = 6'h00; Funct = 6'h20;
        tick(); settle();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("to_wait%0d", i), {Estado, Excecao}, {4'd1, 1'b0});
            tick(); settle();
        end
        chk("to_excecao", {Estado, Excecao}, {4'd13, 1'b1});
        MemPronta = 1'b1;
        tick(); tick(); settle();
        chk("to_sticky", {Estado, Excecao, IRWrite, PCWrite}, {4'd13, 3'b100});

        // MemPronta on the limit cycle wins over the timeout
        reset = 1'b1; tick();
        reset = 1'b0; MemPronta = 1'b0;
        tick(); settle();
        repeat (14) tick();
        MemPronta = 1'b1; settle();
        chk("race_fetch", {Estado, IRWrite}, {4'd1, 1'b1});
        tick(); settle();
        chk("race_decode", Estado, 4'd2);

        // Illegal opcode from a fresh reset
        reset = 1'b1; tick();
        reset = 1'b0; Opcode = 6'h3F;
        tick(); tick(); settle();
        chk("badop_decode", Estado, 4'd2);
        tick(); settle();
        chk("badop_excecao", {Estado, Excecao}, {4'd13, 1'b1});
        reset = 1'b1; tick(); settle();
        chk("clear_excecao", {Estado, Excecao}, {4'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
